// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared state encodings, digit width and sizing helper
package bin2bcd_seq_pkg;
    localparam int BCD_DIGIT_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// bcd_digit_adj: double-dabble add-3 correction for one BCD digit
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x_i,
    output logic [BCD_DIGIT_W-1:0] y_o
);
    assign y_o = (x_i > 4'd4) ? x_i + 4'd3 : x_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble binary to BCD converter with handshakes
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          neg_out,
    output logic                          ovf_out
);
    localparam int CW = clog2(WIDTH + 1);
    localparam int AW = BCD_DIGIT_W * DIGITS;
    state_e         state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [AW-1:0]  acc_q, acc_d, adj;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d, ovf_q, ovf_d, carry, in_neg;
    logic [WIDTH-1:0] mag;
    assign in_neg = SIGNED && bin_in[WIDTH-1];
    assign mag    = in_neg ? -bin_in : bin_in;
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .x_i(acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .y_o(adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end
    // accept in IDLE, shift WIDTH times (one extra cycle to enter DONE), hold result until taken
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        carry     = 1'b0;
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        if (state_q == IDLE && in_valid) begin
            state_d = SHIFT;
            sh_d    = mag;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = in_neg;
            ovf_d   = 1'b0;
        end else if (state_q == SHIFT) begin
            if (cnt_q == CW'(WIDTH)) begin
                state_d = DONE;
            end else begin
                {carry, acc_d, sh_d} = {adj, sh_q, 1'b0};
                ovf_d = ovf_q | carry;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    assign bcd_out = acc_q;
    assign neg_out = neg_q;
    assign ovf_out = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for an unsigned 9b/3-digit and a signed 8b/2-digit converter
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic va, ra, ova, ora, nega, ovfa;
    logic [8:0] bina;
    logic [11:0] bcda;
    logic vb, rb, ovb, orb, negb, ovfb;
    logic [7:0] binb;
    logic [7:0] bcdb;
    int checks = 0;
    int errors = 0;
    logic [13:0] qa[$];
    logic [9:0] qb[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(9), .DIGITS(3), .SIGNED(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .bin_in(bina),
        .out_valid(ova), .out_ready(ora), .bcd_out(bcda), .neg_out(nega), .ovf_out(ovfa)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .bin_in(binb),
        .out_valid(ovb), .out_ready(orb), .bcd_out(bcdb), .neg_out(negb), .ovf_out(ovfb)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] bcd3(input int v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // scoreboard monitors: compare each accepted result against the oldest expectation
    always @(negedge clk) begin
        if (!rst && ova && ora) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_result got=%h", {ovfa, nega, bcda});
            end else begin
                logic [13:0] e;
                e = qa.pop_front();
                if ({ovfa, nega, bcda} !== e) begin
                    errors++;
                    $display("FAIL a_result got=%h exp=%h", {ovfa, nega, bcda}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ovb && orb) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_result got=%h", {ovfb, negb, bcdb});
            end else begin
                logic [9:0] e;
                e = qb.pop_front();
                if ({ovfb, negb, bcdb} !== e) begin
                    errors++;
                    $display("FAIL b_result got=%h exp=%h", {ovfb, negb, bcdb}, e);
                end
            end
        end
    end

    task automatic send_a(input logic [8:0] v, input logic [13:0] e);
        int n;
        n = 0;
        while (!ra && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ra) begin
            check("a_in_ready_timeout", ra, 1);
            return;
        end
        va = 1'b1;
        bina = v;
        qa.push_back(e);
        @(posedge clk); #1;
        va = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v, input logic [9:0] e);
        int n;
        n = 0;
        while (!rb && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rb) begin
            check("b_in_ready_timeout", rb, 1);
            return;
        end
        vb = 1'b1;
        binb = v;
        qb.push_back(e);
        @(posedge clk); #1;
        vb = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            check("drain_pending", qa.size() + qb.size(), 0);
            qa.delete();
            qb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1);
    end

    initial begin
        int n;
        va = 1'b0; vb = 1'b0; bina = '0; binb = '0; ora = 1'b1; orb = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_a_in_ready", ra, 1);
        check("rst_a_out_valid", ova, 0);
        check("rst_a_bcd", bcda, 0);
        check("rst_a_neg_ovf", {nega, ovfa}, 0);
        check("rst_b_in_ready", rb, 1);
        check("rst_b_out_valid", ovb, 0);
        check("rst_b_bcd_neg_ovf", {ovfb, negb, bcdb}, 0);

        send_a(9'd0, {2'b00, 12'h000});
        drain();

        va = 1'b1; bina = 9'd511; qa.push_back({2'b00, 12'h511});
        @(posedge clk); #1;
        va = 1'b0;
        n = 0;
        while (!ova && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_latency", n, 10);
        drain();

        send_a(9'd1,   {2'b00, 12'h001});
        send_a(9'd99,  {2'b00, 12'h099});
        send_a(9'd100, {2'b00, 12'h100});
        send_a(9'd409, {2'b00, 12'h409});
        send_b(8'h80, {1'b1, 1'b1, 8'h28});
        send_b(8'hFF, {1'b0, 1'b1, 8'h01});
        send_b(8'h7F, {1'b1, 1'b0, 8'h27});
        send_b(8'd99, {1'b0, 1'b0, 8'h99});
        send_b(8'd100, {1'b1, 1'b0, 8'h00});
        send_b(8'h00, {1'b0, 1'b0, 8'h00});
        send_b(8'h9D, {1'b0, 1'b1, 8'h99});
        send_b(8'h9C, {1'b1, 1'b1, 8'h00});
        send_b(8'hF6, {1'b0, 1'b1, 8'h10});
        drain();

        ora = 1'b0;
        send_a(9'd300, {2'b00, 12'h300});
        n = 0;
        while (!ova && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_bcd_stable", bcda, 12'h300);
            check("bp_in_ready_low", ra, 0);
            check("bp_out_valid_held", ova, 1);
            va = 1'b1;
            bina = 9'd7;
            @(posedge clk); #1;
        end
        va = 1'b0;
        ora = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready", ra, 1);
        check("bp_idle_out_valid", ova, 0);
        send_a(9'd42, {2'b00, 12'h042});
        drain();

        va = 1'b1; bina = 9'd200;
        @(posedge clk); #1;
        va = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", ra, 1);
        check("abort_out_valid", ova, 0);
        check("abort_bcd", bcda, 0);
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_result", ova, 0);
        send_a(9'd255, {2'b00, 12'h255});
        drain();

        for (int i = 0; i < 20; i++) begin
            int v;
            v = int'($urandom_range(0, 511));
            send_a(9'(v), {2'b00, bcd3(v)});
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
